vram_writer: RTL and testbench

//  Bus-master write engine for the shared 64 KB zram.

---
 rtl/vram_writer.sv | 231 +++++++++++++++++++++++
 tb/tb_vram_writer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_writer.sv
// -----------------------------------------------------------------------------
// vram_writer
//   Bus-master write engine for the shared zram. Fills a byte range with a
//   constant or (optionally) copies a byte range upward in ascending order, so
//   video memory can be cleared or scrolled without CPU cycles.
//
//   Optional feature macro: VRAM_COPY_EN
//     defined   -> copy states are built; mode=1 performs a copy
//     undefined -> fill-only engine; mode, src and i_data are ignored
//
// Parameters
//   AW  address width (all address arithmetic wraps modulo 2^AW)
//   DW  data width
//
// Ports
//   clock    in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   start    in   one-cycle request, only honoured in IDLE
//   mode     in   0 = fill, 1 = copy
//   dst      in   first destination address
//   src      in   first source address (copy only)
//   length   in   byte count, 0 means 2^AW bytes
//   pattern  in   fill value
//   abort    in   synchronous cancel, no done pulse
//   address  out  zram address (registered)
//   i_data   in   zram read data, one cycle after its address
//   o_data   out  zram write data
//   we       out  zram write enable (registered)
//   busy     out  engine owns the zram port (registered)
//   done     out  one-cycle completion pulse (registered)
// -----------------------------------------------------------------------------
module vram_writer #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] length,
    input  logic [DW-1:0] pattern,
    input  logic          abort,
    output logic [AW-1:0] address,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data,
    output logic          we,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILL    = 3'd1,
        S_COPY_RD = 3'd2,
        S_COPY_WR = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [AW-1:0] ONE = AW'(1);

    state_t        state_reg,   state_next;
    // Next destination address to be driven (dst + i for the following byte)
    logic [AW-1:0] dst_ptr_reg, dst_ptr_next;
    // Bytes still to go after the one currently on the bus. Loading length-1
    // makes length=0 naturally mean 2^AW bytes.
    logic [AW-1:0] cnt_reg,     cnt_next;
    logic [DW-1:0] pattern_reg, pattern_next;
    logic [AW-1:0] address_reg, address_next;
    logic [DW-1:0] o_data_reg,  o_data_next;
    logic          we_reg,      we_next;
    logic          busy_reg,    busy_next;
    logic          done_reg,    done_next;

`ifdef VRAM_COPY_EN
    // Next source address to be read (src + i for the following byte)
    logic [AW-1:0] src_ptr_reg, src_ptr_next;
`else
    // Fill-only build: these inputs are intentionally left without a load.
    logic unused_inputs;
    assign unused_inputs = ^{mode, src, i_data};
`endif

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            dst_ptr_reg <= '0;
            cnt_reg     <= '0;
            pattern_reg <= '0;
            address_reg <= '0;
            o_data_reg  <= '0;
            we_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
`ifdef VRAM_COPY_EN
            src_ptr_reg <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            dst_ptr_reg <= dst_ptr_next;
            cnt_reg     <= cnt_next;
            pattern_reg <= pattern_next;
            address_reg <= address_next;
            o_data_reg  <= o_data_next;
            we_reg      <= we_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
`ifdef VRAM_COPY_EN
            src_ptr_reg <= src_ptr_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Outputs are computed one cycle
    // ahead so that the registered values describe the current state.
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        dst_ptr_next = dst_ptr_reg;
        cnt_next     = cnt_reg;
        pattern_next = pattern_reg;
        address_next = address_reg;   // address holds its value when idle
        o_data_next  = o_data_reg;
        we_next      = 1'b0;
        busy_next    = 1'b0;
        done_next    = 1'b0;
`ifdef VRAM_COPY_EN
        src_ptr_next = src_ptr_reg;
`endif

        case (state_reg)
            S_IDLE: begin
                // abort wins over a simultaneous start
                if (start && !abort) begin
                    pattern_next = pattern;
                    cnt_next     = length - ONE;
                    busy_next    = 1'b1;
`ifdef VRAM_COPY_EN
                    if (mode) begin
                        state_next   = S_COPY_RD;
                        address_next = src;
                        src_ptr_next = src + ONE;
                        dst_ptr_next = dst;
                    end else
`endif
                    begin
                        state_next   = S_FILL;
                        address_next = dst;
                        o_data_next  = pattern;
                        we_next      = 1'b1;
                        dst_ptr_next = dst + ONE;
                    end
                end
            end

            S_FILL: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (cnt_reg == '0) begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                end else begin
                    address_next = dst_ptr_reg;
                    dst_ptr_next = dst_ptr_reg + ONE;
                    cnt_next     = cnt_reg - ONE;
                    o_data_next  = pattern_reg;
                    we_next      = 1'b1;
                    busy_next    = 1'b1;
                end
            end

`ifdef VRAM_COPY_EN
            S_COPY_RD: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else begin
                    // Read data for this source byte arrives during COPY_WR
                    state_next   = S_COPY_WR;
                    address_next = dst_ptr_reg;
                    dst_ptr_next = dst_ptr_reg + ONE;
                    we_next      = 1'b1;
                    busy_next    = 1'b1;
                end
            end

            S_COPY_WR: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (cnt_reg == '0) begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                end else begin
                    state_next   = S_COPY_RD;
                    address_next = src_ptr_reg;
                    src_ptr_next = src_ptr_reg + ONE;
                    cnt_next     = cnt_reg - ONE;
                    busy_next    = 1'b1;
                end
            end
`endif

            S_DONE: begin
                // start is deliberately not sampled here
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign address = address_reg;
    assign we      = we_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

`ifdef VRAM_COPY_EN
    // The copy write passes read data straight through; it became valid one
    // cycle after the COPY_RD address, i.e. during this COPY_WR cycle.
    assign o_data = (state_reg == S_COPY_WR) ? i_data : o_data_reg;
`else
    assign o_data = o_data_reg;
`endif

endmodule

// File: tb/tb_vram_writer.sv
// -----------------------------------------------------------------------------
// tb_vram_writer
//   Self-checking bench for vram_writer. A behavioural zram model sits on the
//   port; a reference image of memory plus an expected write list are computed
//   from plain arithmetic and compared with what the engine actually did.
// -----------------------------------------------------------------------------
module tb_vram_writer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [15:0] dst;
    logic [15:0] src;
    logic [15:0] length;
    logic [7:0]  pattern;
    logic        abort;
    logic [15:0] address;
    logic [7:0]  i_data;
    logic [7:0]  o_data;
    logic        we;
    logic        busy;
    logic        done;

    always #5 clock = ~clock;

    vram_writer #(.AW(16), .DW(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .dst     (dst),
        .src     (src),
        .length  (length),
        .pattern (pattern),
        .abort   (abort),
        .address (address),
        .i_data  (i_data),
        .o_data  (o_data),
        .we      (we),
        .busy    (busy),
        .done    (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- zram model ----------------
    int unsigned salt;
    logic [7:0]  mem [0:65535];
    bit          mem_ready = 1'b0;

    function automatic logic [7:0] init_byte(input int unsigned a, input int unsigned s);
        return 8'((a * 37) ^ (a >> 8) ^ s);
    endfunction

    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 65536; i++) mem[i] = init_byte(i, salt);
            mem_ready = 1'b1;
        end
        i_data <= mem[address];
        if (we) mem[address] = o_data;
    end

    // ---------------- bus monitor ----------------
    int          cyc = 0;   // number of rising edges so far
    logic [15:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    int          done_cnt = 0;
    int          busy_cnt = 0;
    int          last_done_cyc = -1;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (we) begin
            wr_addr_q.push_back(address);
            wr_data_q.push_back(o_data);
        end
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] exp_addr_q[$];
    logic [7:0]  exp_data_q[$];
    int          accept_edge;
    bit          timed_out;

    function automatic void model_fill(input logic [15:0] d, input logic [15:0] l,
                                       input logic [7:0] p);
        int n = (l == 0) ? 65536 : int'(l);
        for (int i = 0; i < n; i++) begin
            ref_mem[16'(d + i)] = p;
            exp_addr_q.push_back(16'(d + i));
            exp_data_q.push_back(p);
        end
    endfunction

    // Ascending byte-by-byte copy; overlapping ranges see earlier writes.
    function automatic void model_copy(input logic [15:0] d, input logic [15:0] s,
                                       input logic [15:0] l);
        int n = (l == 0) ? 65536 : int'(l);
        logic [7:0] v;
        for (int i = 0; i < n; i++) begin
            v = ref_mem[16'(s + i)];
            ref_mem[16'(d + i)] = v;
            exp_addr_q.push_back(16'(d + i));
            exp_data_q.push_back(v);
        end
    endfunction

    function automatic int write_errs(input int mark);
        int e = 0;
        int got = wr_addr_q.size() - mark;
        if (got != exp_addr_q.size()) e++;
        for (int i = 0; i < got && i < exp_addr_q.size(); i++)
            if (wr_addr_q[mark + i] !== exp_addr_q[i] || wr_data_q[mark + i] !== exp_data_q[i])
                e++;
        return e;
    endfunction

    function automatic int mem_diffs();
        int e = 0;
        for (int i = 0; i < 65536; i++)
            if (mem[i] !== ref_mem[i]) e++;
        return e;
    endfunction

    // Drive one request and wait (bounded) for its done pulse.
    task automatic run_op(input logic m, input logic [15:0] d, input logic [15:0] s,
                          input logic [15:0] l, input logic [7:0] p, input int budget);
        int d0;
        d0 = done_cnt;
        @(negedge clock);
        mode = m; dst = d; src = s; length = l; pattern = p; start = 1'b1;
        accept_edge = cyc + 1;
        @(posedge clock);
        #1 start = 1'b0;
        timed_out = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            #1;
            if (done_cnt != d0) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (3) @(negedge clock);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_checks += 5;
        if (address !== 16'h0) begin n_fail++; $display("FAIL reset_address got=%h want=0000", address); end
        if (o_data  !== 8'h0)  begin n_fail++; $display("FAIL reset_o_data got=%h want=00", o_data); end
        if (we      !== 1'b0)  begin n_fail++; $display("FAIL reset_we got=%b want=0", we); end
        if (busy    !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (done    !== 1'b0)  begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i, salt);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if (busy !== 1'b0 || we !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset busy=%b we=%b want 0/0", busy, we);
        end
        $display("reset: outputs checked");
    endtask

    // One complete transfer with all of its checks.
    task automatic test_transfer(input string name, input logic m, input logic [15:0] d,
                                 input logic [15:0] s, input logic [15:0] l,
                                 input logic [7:0] p, input bit is_copy);
        int mark, d0, b0, n, cyc_per, e, md;
        exp_addr_q.delete();
        exp_data_q.delete();
        mark = wr_addr_q.size();
        d0 = done_cnt;
        b0 = busy_cnt;
        n = (l == 0) ? 65536 : int'(l);
        cyc_per = is_copy ? 2 : 1;
        if (is_copy) model_copy(d, s, l);
        else         model_fill(d, l, p);
        run_op(m, d, s, l, p, n * cyc_per + 20);
        e  = write_errs(mark);
        md = mem_diffs();
        $display("xfer %s mode=%0d dst=%h src=%h len=%0d pat=%h writes=%0d done_at=+%0d",
                 name, m, d, s, n, p, wr_addr_q.size() - mark, last_done_cyc - accept_edge);
        n_checks += 6;
        if (timed_out) begin n_fail++; $display("FAIL %s timeout: no done within budget", name); end
        if (e != 0) begin n_fail++; $display("FAIL %s writes: %0d bad entries, want 0 (got %0d writes, want %0d)", name, e, wr_addr_q.size() - mark, n); end
        if (md != 0) begin n_fail++; $display("FAIL %s memory: %0d bytes differ, want 0", name, md); end
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL %s done_count got=%0d want=1", name, done_cnt - d0); end
        if (last_done_cyc - accept_edge != n * cyc_per) begin n_fail++; $display("FAIL %s done_latency got=%0d want=%0d", name, last_done_cyc - accept_edge, n * cyc_per); end
        if (busy_cnt - b0 != n * cyc_per) begin n_fail++; $display("FAIL %s busy_cycles got=%0d want=%0d", name, busy_cnt - b0, n * cyc_per); end
    endtask

    task automatic test_fill();
        test_transfer("fill_4000", 1'b0, 16'h4000, 16'h0, 16'd16, 8'hAA, 1'b0);
    endtask

    task automatic test_wrap();
        test_transfer("wrap_fill", 1'b0, 16'hFFFE, 16'h0, 16'd4, 8'h55, 1'b0);
    endtask

    task automatic test_copy();
`ifdef VRAM_COPY_EN
        for (int i = 0; i < 8; i++)
            test_transfer("preload", 1'b0, 16'(16'h1000 + i), 16'h0, 16'd1, 8'(i + 1), 1'b0);
        test_transfer("copy_2000", 1'b1, 16'h2000, 16'h1000, 16'd8, 8'h00, 1'b1);
        test_transfer("copy_overlap_up", 1'b1, 16'h1003, 16'h1000, 16'd10, 8'h00, 1'b1);
        test_transfer("copy_overlap_dn", 1'b1, 16'h0FFE, 16'h1000, 16'd10, 8'h00, 1'b1);
        test_transfer("copy_wrap", 1'b1, 16'hFFFC, 16'h2000, 16'd6, 8'h00, 1'b1);
`else
        // Without the copy feature, mode=1 must behave exactly like a fill.
        test_transfer("mode1_is_fill", 1'b1, 16'h2000, 16'h1000, 16'd8, 8'h3C, 1'b0);
`endif
    endtask

    task automatic test_back_to_back();
        int mark, d0, b0;
        logic [7:0] p;
        p = 8'($urandom);
        exp_addr_q.delete();
        exp_data_q.delete();
        mark = wr_addr_q.size();
        d0 = done_cnt;
        b0 = busy_cnt;
        model_fill(16'h5000, 16'd12, p);
        @(negedge clock);
        mode = 1'b0; dst = 16'h5000; length = 16'd12; pattern = p; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int k = 0; k < 50 && busy_cnt - b0 < 4; k++) begin @(negedge clock); #1; end
        // second request while busy: must be dropped
        dst = 16'h6000; length = 16'd5; pattern = ~p; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int k = 0; k < 50 && done_cnt == d0; k++) begin @(negedge clock); #1; end
        // a request during the DONE cycle must also be dropped
        dst = 16'h7000; length = 16'd3; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (6) @(negedge clock);
        #1;
        $display("back_to_back: writes=%0d dones=%0d", wr_addr_q.size() - mark, done_cnt - d0);
        n_checks += 4;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL b2b done_count got=%0d want=1", done_cnt - d0); end
        if (write_errs(mark) != 0) begin n_fail++; $display("FAIL b2b writes got=%0d writes, want 12 to 5000..500B", wr_addr_q.size() - mark); end
        if (mem_diffs() != 0) begin n_fail++; $display("FAIL b2b memory: %0d bytes differ, want 0", mem_diffs()); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b busy_after got=%b want=0", busy); end
    endtask

    task automatic test_abort();
        int mark, d0, b0;
        logic [7:0] p;
        p = 8'($urandom);
        exp_addr_q.delete();
        exp_data_q.delete();
        mark = wr_addr_q.size();
        d0 = done_cnt;
        b0 = busy_cnt;
        // abort sampled at the end of the 10th busy cycle: that write completes
        model_fill(16'h0000, 16'd10, p);
        @(negedge clock);
        mode = 1'b0; dst = 16'h0000; length = 16'd100; pattern = p; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int k = 0; k < 50 && busy_cnt - b0 < 10; k++) begin @(negedge clock); #1; end
        abort = 1'b1;
        @(posedge clock);
        #1 abort = 1'b0;
        @(negedge clock);
        #1;
        n_checks += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b want=0", busy); end
        if (we !== 1'b0) begin n_fail++; $display("FAIL abort_we got=%b want=0", we); end
        repeat (5) @(negedge clock);
        #1;
        $display("abort: writes=%0d dones=%0d", wr_addr_q.size() - mark, done_cnt - d0);
        n_checks += 3;
        if (write_errs(mark) != 0) begin n_fail++; $display("FAIL abort_writes got=%0d want=10", wr_addr_q.size() - mark); end
        if (done_cnt != d0) begin n_fail++; $display("FAIL abort_done got=%0d pulses want=0", done_cnt - d0); end
        if (mem_diffs() != 0) begin n_fail++; $display("FAIL abort_memory: %0d bytes differ, want 0", mem_diffs()); end
    endtask

    task automatic test_abort_start_idle();
        int mark, d0, b0;
        mark = wr_addr_q.size();
        d0 = done_cnt;
        b0 = busy_cnt;
        @(negedge clock);
        mode = 1'b0; dst = 16'h8000; length = 16'd4; pattern = 8'h99;
        start = 1'b1; abort = 1'b1;
        @(posedge clock);
        #1 start = 1'b0; abort = 1'b0;
        repeat (6) @(negedge clock);
        #1;
        $display("abort_with_start: busy_cycles=%0d writes=%0d", busy_cnt - b0, wr_addr_q.size() - mark);
        n_checks += 3;
        if (busy_cnt != b0) begin n_fail++; $display("FAIL abort_start_busy got=%0d cycles want=0", busy_cnt - b0); end
        if (wr_addr_q.size() != mark) begin n_fail++; $display("FAIL abort_start_writes got=%0d want=0", wr_addr_q.size() - mark); end
        if (done_cnt != d0) begin n_fail++; $display("FAIL abort_start_done got=%0d want=0", done_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        int mark;
        logic [7:0] p;
        p = 8'($urandom);
        exp_addr_q.delete();
        exp_data_q.delete();
        mark = wr_addr_q.size();
        // reset lands during the 5th write, before its clock edge: 4 bytes stick
        model_fill(16'h3000, 16'd4, p);
        @(negedge clock);
        mode = 1'b0; dst = 16'h3000; length = 16'd20; pattern = p; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int k = 0; k < 50 && wr_addr_q.size() - mark < 5; k++) begin @(negedge clock); #1; end
        #1 reset = 1'b1;
        #1;
        n_checks += 3;
        if (we !== 1'b0) begin n_fail++; $display("FAIL reset_mid_we got=%b want=0", we); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy got=%b want=0", busy); end
        if (address !== 16'h0) begin n_fail++; $display("FAIL reset_mid_address got=%h want=0000", address); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        $display("reset_mid: writes seen=%0d", wr_addr_q.size() - mark);
        n_checks += 2;
        if (wr_addr_q.size() - mark != 5) begin n_fail++; $display("FAIL reset_mid_writes got=%0d want=5", wr_addr_q.size() - mark); end
        if (mem_diffs() != 0) begin n_fail++; $display("FAIL reset_mid_memory: %0d bytes differ, want 0", mem_diffs()); end
        test_transfer("after_reset", 1'b0, 16'($urandom), 16'h0, 16'($urandom_range(1, 30)), 8'($urandom), 1'b0);
    endtask

    task automatic test_random();
        logic m;
        for (int t = 0; t < 12; t++) begin
`ifdef VRAM_COPY_EN
            m = 1'($urandom);
            test_transfer("random", m, 16'($urandom), 16'($urandom),
                          16'($urandom_range(1, 48)), 8'($urandom), m);
`else
            m = 1'($urandom);
            test_transfer("random", m, 16'($urandom), 16'($urandom),
                          16'($urandom_range(1, 48)), 8'($urandom), 1'b0);
`endif
        end
    endtask

    task automatic test_full_length();
        test_transfer("full_64k", 1'b0, 16'($urandom), 16'h0, 16'd0, 8'($urandom), 1'b0);
    endtask

    initial begin
        salt    = $urandom;
        reset   = 1'b1;
        start   = 1'b0;
        mode    = 1'b0;
        abort   = 1'b0;
        dst     = '0;
        src     = '0;
        length  = '0;
        pattern = '0;
        test_reset();
        test_fill();
        test_wrap();
        test_copy();
        test_back_to_back();
        test_abort();
        test_abort_start_idle();
        test_reset_mid();
        test_random();
        test_full_length();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
